// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic/shift/count unit with valid/ready handshake on both sides.
// Optional popcount/CLZ hardware is enabled by defining LOGIC_UNIT_CNT_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_XOR    = 4'd1;
    localparam logic [3:0] OP_NAND   = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_NOT    = 4'd4;
    localparam logic [3:0] OP_NOR    = 4'd5;
    localparam logic [3:0] OP_NEG    = 4'd6;
    localparam logic [3:0] OP_XNOR   = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_ROL    = 4'd11;
    localparam logic [3:0] OP_POPCNT = 4'd12;
    localparam logic [3:0] OP_CLZ    = 4'd13;
    localparam logic [3:0] OP_ANDN   = 4'd14;
    localparam logic [3:0] OP_ORN    = 4'd15;

    localparam logic [SHW:0] WIDTH_SH = (SHW + 1)'(WIDTH);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s1_adv;
    logic             s2_adv;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             res_illegal;
    logic [WIDTH-1:0] pop_cnt;
    logic [WIDTH-1:0] clz_cnt;

    // A stage may advance when its downstream slot is empty or being drained this cycle.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: operand capture. Payload only loads on a real transfer so idle X cannot leak in.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // NOTE: the payload is small and reset to 0 so the datapath never starts from unknown state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    assign sh = s1_b[SHW-1:0];

`ifdef LOGIC_UNIT_CNT_EN
    // Population count and count-leading-zeros; the highest set bit wins the CLZ scan.
    always_comb begin
        pop_cnt = '0;
        clz_cnt = WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + WIDTH'(s1_a[i]);
            if (s1_a[i]) begin
                clz_cnt = WIDTH'(WIDTH - 1 - i);
            end
        end
    end
`else
    assign pop_cnt = '0;
    assign clz_cnt = '0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        res         = '0;
        res_illegal = 1'b0;
        case (s1_op)
            OP_AND:  res = s1_a & s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_NAND: res = ~(s1_a & s1_b);
            OP_OR:   res = s1_a | s1_b;
            OP_NOT:  res = ~s1_a;
            OP_NOR:  res = ~(s1_a | s1_b);
            OP_NEG:  res = (~s1_a) + WIDTH'(1);
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_SLL:  res = s1_a << sh;
            OP_SRL:  res = s1_a >> sh;
            OP_SRA:  res = $unsigned($signed(s1_a) >>> sh);
            // A right shift by WIDTH yields 0, so sh == 0 degenerates cleanly to A.
            OP_ROL:  res = (s1_a << sh) | (s1_a >> (WIDTH_SH - {1'b0, sh}));
`ifdef LOGIC_UNIT_CNT_EN
            OP_POPCNT: res = pop_cnt;
            OP_CLZ:    res = clz_cnt;
`else
            OP_POPCNT: res_illegal = 1'b1;
            OP_CLZ:    res_illegal = 1'b1;
`endif
            OP_ANDN: res = s1_a & ~s1_b;
            OP_ORN:  res = s1_a | ~s1_b;
            default: res = '0;
        endcase
    end

    // Stage 2: result and flags, held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= res;
                out_zero    <= (res == '0);
                out_neg     <= res[WIDTH-1];
                out_illegal <= res_illegal;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=32 main instance, WIDTH=8 SRA instance).
// Expectations for opcodes 12/13 follow whether LOGIC_UNIT_CNT_EN is defined for the build.
module tb_logic_unit_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_illegal;

    logic        in_valid8;
    logic        in_ready8;
    logic [3:0]  in_op8;
    logic [7:0]  in_a8;
    logic [7:0]  in_b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic        out_zero8;
    logic        out_neg8;
    logic        out_illegal8;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   inflight = 0;
    int   first_in_cyc;
    int   first_out_cyc;
    int   last_out_cyc;
    bit   rand_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_flags;
    exp_t cur_exp;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .out_illegal(out_illegal)
    );

    logic_unit_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_zero(out_zero8), .out_neg(out_neg8), .out_illegal(out_illegal8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: evaluate handshakes just after the negedge, score outputs, then advance.
    task automatic cycle(output bit in_fire);
        bit   out_fire;
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        cyc++;
        check("in_ready", {31'd0, in_ready}, {31'd0, !(inflight == 2 && !out_ready)});
        if (prev_stall) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", out_data, prev_data);
            check("stall_flags", {29'd0, out_zero, out_neg, out_illegal}, {29'd0, prev_flags});
        end
        out_fire = out_valid && out_ready;
        in_fire  = in_valid && in_ready;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", out_data, e.data);
                check("zero", {31'd0, out_zero}, {31'd0, e.data == 32'd0});
                check("neg", {31'd0, out_neg}, {31'd0, e.data[31]});
                check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
            inflight--;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        if (in_fire) begin
            exp_q.push_back(cur_exp);
            inflight++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_flags = {out_zero, out_neg, out_illegal};
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_ill);
        bit fired = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        cur_exp  = '{data: exp_data, ill: exp_ill};
        for (int n = 0; n < 50 && !fired; n++) cycle(fired);
        if (!fired) check("send_timeout", {31'd0, fired}, 32'd1);
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_op    = 'x;
        in_a     = 'x;
        in_b     = 'x;
    endtask

    task automatic drain();
        bit f;
        go_idle();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycle(f);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        bit f;
        rst_n = 1'b0;
        go_idle();
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_op8     = '0;
        in_a8      = '0;
        in_b8      = '0;
        out_ready8 = 1'b1;
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {29'd0, out_zero, out_neg, out_illegal}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(f);

        // Logic sweep, back-to-back, with latency and throughput
        first_in_cyc  = -1;
        first_out_cyc = -1;
        send(4'd0,  32'h0001FFC1, 32'h000000BC, 32'h00000080, 1'b0);
        send(4'd1,  32'h0001FFC1, 32'h000000BC, 32'h0001FF7D, 1'b0);
        send(4'd2,  32'h0001FFC1, 32'h000000BC, 32'hFFFFFF7F, 1'b0);
        send(4'd3,  32'h0001FFC1, 32'h000000BC, 32'h0001FFFD, 1'b0);
        send(4'd4,  32'h0001FFC1, 32'h000000BC, 32'hFFFE003E, 1'b0);
        send(4'd5,  32'h0001FFC1, 32'h000000BC, 32'hFFFE0002, 1'b0);
        send(4'd6,  32'h0001FFC1, 32'h000000BC, 32'hFFFE003F, 1'b0);
        send(4'd7,  32'h0001FFC1, 32'h000000BC, 32'hFFFE0082, 1'b0);
        send(4'd14, 32'h0001FFC1, 32'h000000BC, 32'h0001FF41, 1'b0);
        send(4'd15, 32'h0001FFC1, 32'h000000BC, 32'hFFFFFFC3, 1'b0);
        drain();
        check("latency", first_out_cyc - first_in_cyc, 32'd2);
        check("throughput", last_out_cyc - first_out_cyc, 32'd9);

        // Shifts, upper B bits ignored
        send(4'd8,  32'h80000001, 32'h00000021, 32'h00000002, 1'b0);
        send(4'd9,  32'h80000001, 32'h00000021, 32'h40000000, 1'b0);
        send(4'd10, 32'h80000001, 32'h00000021, 32'hC0000000, 1'b0);
        send(4'd11, 32'h80000001, 32'h00000021, 32'h00000003, 1'b0);
        drain();

        // Counts
`ifdef LOGIC_UNIT_CNT_EN
        send(4'd12, 32'hF0F0F0F0, 32'h0, 32'd16, 1'b0);
        send(4'd13, 32'h00010000, 32'h0, 32'd15, 1'b0);
        send(4'd13, 32'h00000000, 32'h0, 32'd32, 1'b0);
`else
        send(4'd12, 32'hF0F0F0F0, 32'h0, 32'd0, 1'b1);
        send(4'd13, 32'h00010000, 32'h0, 32'd0, 1'b1);
        send(4'd13, 32'h00000000, 32'h0, 32'd0, 1'b1);
`endif
        drain();

        // Boundary NEG cases
        send(4'd6, 32'h80000000, 32'h0, 32'h80000000, 1'b0);
        send(4'd6, 32'h00000000, 32'h0, 32'h00000000, 1'b0);
        drain();

        // Backpressure with a random consumer
        rand_ready = 1'b1;
        send(4'd0,  32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0);
        send(4'd8,  32'h12345678, 32'h00000004, 32'h23456780, 1'b0);
        send(4'd10, 32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0);
        send(4'd11, 32'h12345678, 32'h00000008, 32'h34567812, 1'b0);
        send(4'd6,  32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        send(4'd9,  32'hF0000000, 32'hFFFFFF24, 32'h0F000000, 1'b0);
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Mid-stream reset with two ops in flight
        send(4'd3, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);
        send(4'd3, 32'h00000F00, 32'h0000F000, 32'h0000FF00, 1'b0);
        go_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_flags", {29'd0, out_zero, out_neg, out_illegal}, 32'd0);
        exp_q.delete();
        inflight   = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        cycle(f);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check("no_stale", {31'd0, out_valid}, 32'd0);
            cycle(f);
        end

        // WIDTH=8 SRA: 0x90 >>> 3 = 0xF2
        in_valid8 = 1'b1;
        in_op8    = 4'd10;
        in_a8     = 8'h90;
        in_b8     = 8'h03;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        #1;
        check("w8_valid", {31'd0, out_valid8}, 32'd1);
        check("w8_sra", {24'd0, out_data8}, 32'h000000F2);
        check("w8_neg", {31'd0, out_neg8}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
